// File: rtl/spi_ram_slave_param.sv
// SPI slave with an integrated single-port RAM. Frames carry a 2-bit command
// followed by an address or data payload, MSB first; read data returns on MISO.
module spi_ram_slave_param #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int AUTO_INC   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);

  localparam int SR_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(SR_W + 2);
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_M1 = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] RD_END    = CNT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WADDR = 3'd2,
    WDATA = 3'd3,
    RADDR = 3'd4,
    RDATA = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SR_W-1:0]         sr_q, sr_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    miso_q, miso_d;
  logic                    frame_err_q, frame_err_d;
  logic [SR_W-1:0]         shift_in_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic                    mem_we_s;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // Out-of-range addresses also wrap to zero so software can always recover.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if ({1'b0, a} >= DEPTH_M1) begin
      return '0;
    end else begin
      return a + ADDR_WIDTH'(1);
    end
  endfunction

  assign shift_in_s = {sr_q[SR_W-2:0], MOSI};
  assign rd_word_s  = in_range(rd_addr_q) ? mem[rd_addr_q] : '0;
  assign MISO       = miso_q;
  assign frame_err  = frame_err_q;

  // Frame sequencing, payload assembly and address/MISO next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    miso_d      = 1'b0;
    frame_err_d = 1'b0;
    mem_we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!SS_n) begin
          state_d = CMD;
          sr_d    = shift_in_s;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          cnt_d = '0;
          sr_d  = '0;
          case ({sr_q[0], MOSI})
            2'b00:   state_d = WADDR;
            2'b01:   state_d = WDATA;
            2'b10:   state_d = RADDR;
            2'b11:   state_d = RDATA;
            default: state_d = IDLE;
          endcase
        end
      end
      WADDR, RADDR: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (cnt_q == ADDR_LAST) begin
          state_d = DONE;
          if (state_q == WADDR) begin
            wr_addr_d = shift_in_s[ADDR_WIDTH-1:0];
          end else begin
            rd_addr_d = shift_in_s[ADDR_WIDTH-1:0];
          end
        end else begin
          sr_d  = shift_in_s;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WDATA: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (cnt_q == DATA_LAST) begin
          state_d  = DONE;
          mem_we_s = in_range(wr_addr_q);
          if (AUTO_INC != 0) begin
            wr_addr_d = next_addr(wr_addr_q);
          end else begin
            wr_addr_d = wr_addr_q;
          end
        end else begin
          sr_d  = shift_in_s;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RDATA: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (cnt_q == '0) begin
          // The MSB goes straight to MISO; the rest is held pre-shifted.
          sr_d                   = '0;
          sr_d[DATA_WIDTH-1:0]   = {rd_word_s[DATA_WIDTH-2:0], 1'b0};
          miso_d                 = rd_word_s[DATA_WIDTH-1];
          cnt_d                  = cnt_q + CNT_W'(1);
          if (AUTO_INC != 0) begin
            rd_addr_d = next_addr(rd_addr_q);
          end else begin
            rd_addr_d = rd_addr_q;
          end
        end else if (cnt_q == RD_END) begin
          state_d = DONE;
        end else begin
          miso_d = sr_q[DATA_WIDTH-1];
          sr_d   = {sr_q[SR_W-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (SS_n) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
    end
  end

  // RAM array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[wr_addr_q] <= shift_in_s[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_spi_ram_slave_param.sv
// Self-checking bench: a default instance and an auto-increment 16-bit/5-word
// instance, driven from vector tables with a MISO bit scoreboard.
module tb_spi_ram_slave_param;

  typedef struct {
    int          inst;
    logic [1:0]  cmd;
    logic [15:0] val;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ss_n = 2'b11;
  logic [1:0] mosi = 2'b00;
  logic [1:0] miso;
  logic [1:0] ferr;
  int         checks = 0;
  int         errors = 0;
  logic       exp_q[$];
  vec_t       va[$];
  vec_t       vb[$];
  vec_t       vc[$];
  vec_t       vd[$];

  spi_ram_slave_param #(.DATA_WIDTH(8), .MEM_DEPTH(256), .ADDR_WIDTH(8), .AUTO_INC(0)) u_def (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]), .frame_err(ferr[0]));

  spi_ram_slave_param #(.DATA_WIDTH(16), .MEM_DEPTH(5), .ADDR_WIDTH(3), .AUTO_INC(1)) u_inc (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]), .frame_err(ferr[1]));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, let the edge happen, then compare against the scoreboard.
  task automatic tick(input int inst, input logic ss, input logic d, input logic fe);
    logic e;
    ss_n[inst] = ss;
    mosi[inst] = d;
    @(posedge clk);
    #1;
    e = 1'b0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("miso", {15'd0, miso[inst]}, {15'd0, e});
    check("frame_err", {15'd0, ferr[inst]}, {15'd0, fe});
  endtask

  task automatic frame(input int inst, input logic [1:0] cmd, input logic [15:0] val,
                       input logic release_ss);
    int aw;
    int dw;
    int n;
    aw = (inst == 0) ? 8 : 3;
    dw = (inst == 0) ? 8 : 16;
    tick(inst, 1'b0, cmd[1], 1'b0);
    tick(inst, 1'b0, cmd[0], 1'b0);
    if (cmd == 2'b11) begin
      for (int k = dw - 1; k >= 0; k--) exp_q.push_back(val[k]);
      exp_q.push_back(1'b0);
      for (int k = 0; k <= dw; k++) tick(inst, 1'b0, 1'($urandom_range(1, 0)), 1'b0);
    end else begin
      n = (cmd == 2'b01) ? dw : aw;
      for (int k = n - 1; k >= 0; k--) tick(inst, 1'b0, val[k], 1'b0);
    end
    if (release_ss) tick(inst, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_vecs(input vec_t q[$]);
    foreach (q[i]) frame(q[i].inst, q[i].cmd, q[i].val, 1'b1);
  endtask

  initial begin
    // Defaults, several patterns, plus auto-increment / wrap / out-of-range on u_inc.
    va.push_back('{0, 2'b00, 16'h000F}); va.push_back('{0, 2'b01, 16'h00AA});
    va.push_back('{0, 2'b10, 16'h000F}); va.push_back('{0, 2'b11, 16'h00AA});
    va.push_back('{0, 2'b00, 16'h0010}); va.push_back('{0, 2'b01, 16'h003C});
    va.push_back('{0, 2'b10, 16'h0010}); va.push_back('{0, 2'b11, 16'h003C});
    va.push_back('{0, 2'b10, 16'h000F}); va.push_back('{0, 2'b11, 16'h00AA});
    va.push_back('{0, 2'b00, 16'h0000}); va.push_back('{0, 2'b01, 16'h005A});
    va.push_back('{0, 2'b00, 16'h0003}); va.push_back('{0, 2'b01, 16'h0055});
    va.push_back('{1, 2'b00, 16'h0004}); va.push_back('{1, 2'b01, 16'h1234});
    va.push_back('{1, 2'b01, 16'hBEEF}); va.push_back('{1, 2'b10, 16'h0004});
    va.push_back('{1, 2'b11, 16'h1234}); va.push_back('{1, 2'b11, 16'hBEEF});
    va.push_back('{1, 2'b01, 16'h1111}); va.push_back('{1, 2'b01, 16'h2222});
    va.push_back('{1, 2'b01, 16'h3333}); va.push_back('{1, 2'b00, 16'h0006});
    va.push_back('{1, 2'b01, 16'hFFFF}); va.push_back('{1, 2'b10, 16'h0006});
    va.push_back('{1, 2'b11, 16'h0000}); va.push_back('{1, 2'b10, 16'h0000});
    va.push_back('{1, 2'b11, 16'hBEEF}); va.push_back('{1, 2'b11, 16'h1111});
    va.push_back('{1, 2'b11, 16'h2222}); va.push_back('{1, 2'b11, 16'h3333});
    va.push_back('{1, 2'b11, 16'h1234}); va.push_back('{1, 2'b11, 16'hBEEF});
    // After the abort: address 3 intact, next frames behave normally.
    vb.push_back('{0, 2'b10, 16'h0003}); vb.push_back('{0, 2'b11, 16'h0055});
    vb.push_back('{0, 2'b01, 16'h0066}); vb.push_back('{0, 2'b10, 16'h0003});
    vb.push_back('{0, 2'b11, 16'h0066});
    // After SS_n held low past DONE: wr_addr stays 0x20, RAM untouched.
    vc.push_back('{0, 2'b01, 16'h0099}); vc.push_back('{0, 2'b10, 16'h0020});
    vc.push_back('{0, 2'b11, 16'h0099}); vc.push_back('{0, 2'b10, 16'h0003});
    vc.push_back('{0, 2'b11, 16'h0066});
    // After a mid-read reset: both address registers are zero, RAM kept.
    vd.push_back('{0, 2'b11, 16'h005A}); vd.push_back('{0, 2'b01, 16'h0077});
    vd.push_back('{0, 2'b10, 16'h0000}); vd.push_back('{0, 2'b11, 16'h0077});
    vd.push_back('{1, 2'b11, 16'hBEEF});

    repeat (2) @(posedge clk);
    #1;
    check("reset_miso0", {15'd0, miso[0]}, 16'd0);
    check("reset_ferr0", {15'd0, ferr[0]}, 16'd0);
    check("reset_miso1", {15'd0, miso[1]}, 16'd0);
    check("reset_ferr1", {15'd0, ferr[1]}, 16'd0);
    rst_n = 1'b1;
    tick(0, 1'b1, 1'b0, 1'b0);

    run_vecs(va);

    // Abort a WR_DATA to address 3 after 5 payload bits.
    tick(0, 1'b0, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick(0, 1'b0, 1'b1, 1'b0);
    tick(0, 1'b1, 1'b0, 1'b1);
    tick(0, 1'b1, 1'b0, 1'b0);
    run_vecs(vb);

    // SS_n stays low after a WR_ADDR; the toggling must not start a new frame.
    frame(0, 2'b00, 16'h0020, 1'b0);
    tick(0, 1'b0, 1'b1, 1'b0);
    tick(0, 1'b0, 1'b1, 1'b0);
    tick(0, 1'b0, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b1, 1'b0);
    tick(0, 1'b0, 1'b1, 1'b0);
    tick(0, 1'b1, 1'b0, 1'b0);
    run_vecs(vc);

    // Reset while shifting out 0x99 from address 0x20, with MISO currently 1.
    frame(0, 2'b10, 16'h0020, 1'b1);
    tick(0, 1'b0, 1'b1, 1'b0);
    tick(0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int k = 0; k < 4; k++) tick(0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_miso", {15'd0, miso[0]}, 16'd0);
    check("async_reset_ferr", {15'd0, ferr[0]}, 16'd0);
    ss_n = 2'b11;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(0, 1'b1, 1'b0, 1'b0);
    run_vecs(vd);

    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_slave_param.md
Name: spi_ram_slave_param

Overview:
Parametrised SPI slave with integrated single-port RAM. It is the successor to the fixed 8-bit/256-word SPI-plus-RAM wrapper. Serial frames on MOSI (sampled while SS_n is low) carry a 2-bit command plus a payload to set addresses, write data or read data. Read data returns MSB-first on MISO. New relative to the fixed-width version:
- configurable address and data width;
- non-power-of-two depth;
- optional address auto-increment;
- a frame-abort error pulse.

Parameters:
DATA_WIDTH, 8, RAM word width and data payload length in bits (>=2)
MEM_DEPTH, 256, number of RAM words (>=2, need not be a power of two)
ADDR_WIDTH, 8, address payload length in bits; must satisfy 2**ADDR_WIDTH >= MEM_DEPTH
AUTO_INC, 0, 1 = write address increments after each data write and read address increments after each data read, wrapping MEM_DEPTH-1 -> 0

Ports:
clk  input  1  system clock; all sampling on rising edge
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select, active low, synchronous to clk
MOSI  input  1  serial data in, sampled at posedge clk while SS_n=0
MISO  output  1  serial data out, registered
frame_err  output  1  one-cycle pulse: SS_n rose before the current frame completed

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; MISO=0; frame_err=0; wr_addr=0; rd_addr=0; bit counter=0.
  - RAM contents are not reset.
- Bit sampling: one MOSI bit per posedge with SS_n=0. The first bit of a frame is sampled on the same edge that leaves IDLE. All fields are MSB first.
- Commands (cmd[1:0]): 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- States: IDLE -> CMD (2 bits) -> {WADDR | WDATA | RADDR | RDATA} -> DONE -> IDLE.
- WR_ADDR / RD_ADDR:
  - Next ADDR_WIDTH bits are the address.
  - The target register (wr_addr or rd_addr) updates on the edge sampling the last bit. Then go to DONE.
- WR_DATA:
  - Next DATA_WIDTH bits are the data.
  - On the edge sampling the last bit: mem[wr_addr] <= assembled word. If AUTO_INC, wr_addr advances on the same edge.
  - If wr_addr >= MEM_DEPTH, the write is dropped (no RAM change) but auto-increment still wraps it to 0. Then go to DONE.
- RD_DATA (MOSI ignored after the command):
  - Let E0 be the edge sampling cmd bit 2.
  - At E1: capture mem[rd_addr] into the shift register and set MISO <= word[DATA_WIDTH-1]. Reading an address >= MEM_DEPTH returns all zeros. If AUTO_INC, rd_addr advances at E1.
  - At E2..E(DATA_WIDTH): MISO shifts out the remaining bits, so bit k is valid from E(k+1) to E(k+2).
  - At E(DATA_WIDTH+1): MISO <= 0; go to DONE.
- DONE: MISO=0. Further MOSI bits are ignored until SS_n is sampled high, then go to IDLE. No frame_err is raised from DONE.
- Abort: SS_n sampled high in CMD, WADDR, WDATA, RADDR or RDATA produces all of the following on that edge:
  - state=IDLE, MISO <= 0, frame_err=1 for exactly that cycle;
  - the partial frame is discarded: no RAM write, no address change (an RD_DATA auto-increment already applied at E1 is kept).
- SS_n high in IDLE: stay in IDLE, no error.
- Back-to-back frames need at least one SS_n-high sample between them. Holding SS_n low after DONE never starts a new frame.
- Reset mid-frame: immediate return to reset values. A RAM write whose last bit has not been sampled never occurs.
- Counters size to clog2(max(ADDR_WIDTH, DATA_WIDTH)+2) bits. There is no combinational path from MOSI to MISO.

Test Plan:
1. Defaults: write addr 0x0F (frame 00_00001111), write data 0xAA (01_10101010), read addr 0x0F (10_00001111), read data (11 + 9 idle clocks) -> MISO shows 1,0,1,0,1,0,1,0 from E1..E8, MISO=0 at E9, frame_err never asserted.
2. AUTO_INC=1, DATA_WIDTH=16, MEM_DEPTH=5, ADDR_WIDTH=3:
   - set wr_addr=4; write 0x1234 then 0xBEEF (wr_addr wraps to 0, so 0xBEEF lands at address 0);
   - set rd_addr=4; read twice -> 0x1234 then 0xBEEF.
3. Same instance: set wr_addr=6 (out of range), write 0xFFFF; set rd_addr=6, read -> 0x0000. Every in-range address keeps its previously written value.
4. Abort: start WR_DATA to addr 3 holding 0x55, raise SS_n after 5 payload bits -> frame_err pulses 1 cycle, addr 3 still reads 0x55, next full frame works normally.
5. rst_n low for 1 cycle during a RD_DATA shift -> MISO=0 immediately, addresses=0, state IDLE. A subsequent RD_ADDR 0 / RD_DATA returns the word written at 0 before the reset.
6. SS_n held low 5 extra clocks after a completed WR_ADDR with MOSI toggling -> no RAM or address change, MISO=0, frame_err=0.
